// File: rtl/counter_pkg.sv
// Shared definitions for the counter_rco timebase stage: default geometry,
// the default count type and a helper giving the largest legal terminal count.
package counter_pkg;

  localparam int COUNTER_WIDTH_DEF = 4;
  localparam int COUNTER_MAX_DEF   = 15;

  typedef logic [COUNTER_WIDTH_DEF-1:0] count_t;

  // Largest value representable in 'width' bits, i.e. the upper bound for MAX_COUNT.
  function automatic longint unsigned count_limit(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage : counter_pkg

// File: rtl/counter_rco.sv
// counter_rco: free-running synchronous up-counter, modulo MAX_COUNT+1, with a
// combinational ripple-carry-out so stages can be cascaded (rco -> en).
// Optional feature macro: COUNTER_CLR_EN adds a synchronous, active-high clr
// input that has priority over en and forces rco low while asserted.
module counter_rco
  import counter_pkg::*;
#(
  parameter int WIDTH     = COUNTER_WIDTH_DEF,
  parameter int MAX_COUNT = COUNTER_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef COUNTER_CLR_EN
  input  logic             clr,
`endif
  output logic [WIDTH-1:0] count,
  output logic             rco
);

  // A terminal count of 0 or one that does not fit in WIDTH bits is unusable.
  if ((MAX_COUNT < 1) || (64'(MAX_COUNT) > count_limit(WIDTH))) begin : g_bad_param
    $error("counter_rco: MAX_COUNT=%0d illegal for WIDTH=%0d", MAX_COUNT, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO    = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;
  logic             clr_s;

`ifdef COUNTER_CLR_EN
  assign clr_s = clr;
`else
  assign clr_s = 1'b0;
`endif

  // Next-state: clear wins, then enabled increment; any value at or above the
  // terminal count (including an upset beyond it) folds back to zero.
  always_comb begin
    count_d = count_q;
    if (clr_s) begin
      count_d = ZERO;
    end else if (en) begin
      if (count_q >= MAX_VAL) begin
        count_d = ZERO;
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State register: asynchronous clear on rst_n low, otherwise load next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  // Carry-out is decoded straight from the register so the next stage's enable
  // lines up with the edge on which this stage wraps.
  assign rco = en & ~clr_s & (count_q == MAX_VAL);

endmodule : counter_rco

// File: tb/tb_counter_rco.sv
// Self-checking bench for counter_rco: a vector table on a MAX_COUNT=9 stage,
// hand-written multi-cycle sequences, a two-stage cascade and randomized enable
// (and clear, when COUNTER_CLR_EN is defined) checked against a modulo model.
module tb_counter_rco;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b, en_c;
  logic       clr;
  logic [3:0] count_a, count_b, count_c0, count_c1;
  logic       rco_a, rco_b, rco_c0, rco_c1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_rco #(.WIDTH(4), .MAX_COUNT(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a),
`ifdef COUNTER_CLR_EN
    .clr(clr),
`endif
    .count(count_a), .rco(rco_a));

  counter_rco #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b),
`ifdef COUNTER_CLR_EN
    .clr(1'b0),
`endif
    .count(count_b), .rco(rco_b));

  counter_rco #(.WIDTH(4), .MAX_COUNT(15)) dut_c0 (
    .clk(clk), .rst_n(rst_n), .en(en_c),
`ifdef COUNTER_CLR_EN
    .clr(1'b0),
`endif
    .count(count_c0), .rco(rco_c0));

  counter_rco #(.WIDTH(4), .MAX_COUNT(15)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .en(rco_c0),
`ifdef COUNTER_CLR_EN
    .clr(1'b0),
`endif
    .count(count_c1), .rco(rco_c1));

  typedef struct {
    logic       en;
    logic       exp_rco;    // rco with this en applied, before the edge
    logic [3:0] exp_count;  // count after the edge
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge, release just after it.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int m_a;
  int rco_hits;
  int t_c;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'd1};
    tbl[1]  = '{1'b1, 1'b0, 4'd2};
    tbl[2]  = '{1'b0, 1'b0, 4'd2};
    tbl[3]  = '{1'b1, 1'b0, 4'd3};
    tbl[4]  = '{1'b1, 1'b0, 4'd4};
    tbl[5]  = '{1'b1, 1'b0, 4'd5};
    tbl[6]  = '{1'b1, 1'b0, 4'd6};
    tbl[7]  = '{1'b1, 1'b0, 4'd7};
    tbl[8]  = '{1'b1, 1'b0, 4'd8};
    tbl[9]  = '{1'b1, 1'b0, 4'd9};
    tbl[10] = '{1'b0, 1'b0, 4'd9};
    tbl[11] = '{1'b1, 1'b1, 4'd0};
    tbl[12] = '{1'b1, 1'b0, 4'd1};
    tbl[13] = '{1'b1, 1'b0, 4'd2};

    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b0;
    en_c  = 1'b0;
    clr   = 1'b0;
    tick();
    tick();
    chk("reset_count", 32'(count_a), 32'd0);
    chk("reset_rco", 32'(rco_a), 32'd0);
    rst_n = 1'b1;

    // 30 enabled edges from 0: count follows i mod 16, rco only at 15.
    rco_hits = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      chk("run30_rco", 32'(rco_a), 32'((i % 16) == 15));
      if (rco_a === 1'b1) rco_hits++;
      tick();
      chk("run30_count", 32'(count_a), 32'((i + 1) % 16));
    end
    n_vec++;
    if (rco_hits != 1) begin
      n_bad++;
      $display("FAIL run30_rco_hits: got %0d expected 1", rco_hits);
    end

    // From 14 advance to 7, then hold with en=0.
    for (int i = 0; i < 9; i++) tick();
    chk("reach7", 32'(count_a), 32'd7);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold7_count", 32'(count_a), 32'd7);
      chk("hold7_rco", 32'(rco_a), 32'd0);
    end
    en_a = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("reach15", 32'(count_a), 32'd15);
    en_a = 1'b0;
    #1;
    chk("at15_en0_rco", 32'(rco_a), 32'd0);
    en_a = 1'b1;
    #1;
    chk("at15_en1_rco", 32'(rco_a), 32'd1);
    tick();
    chk("wrap15", 32'(count_a), 32'd0);

    // Asynchronous reset mid-count, between edges.
    for (int i = 0; i < 9; i++) tick();
    chk("reach9", 32'(count_a), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count_a), 32'd0);
    chk("async_rst_rco", 32'(rco_a), 32'd0);
    tick();
    chk("rst_hold_count", 32'(count_a), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_release", 32'(count_a), 32'd1);

    // Table on the MAX_COUNT=9 stage, starting from reset.
    do_reset();
    chk("b_reset", 32'(count_b), 32'd0);
    for (int i = 0; i < 14; i++) begin
      en_b = tbl[i].en;
      #1;
      chk("tbl_rco", 32'(rco_b), 32'(tbl[i].exp_rco));
      tick();
      chk("tbl_count", 32'(count_b), 32'(tbl[i].exp_count));
    end
    en_b = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (count_b > 4'd9) chk("b_never_above_9", 32'(count_b), 32'd9);
    end
    en_b = 1'b0;

`ifdef COUNTER_CLR_EN
    // Synchronous clear beats enable and masks rco.
    do_reset();
    en_a = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("clr_reach12", 32'(count_a), 32'd12);
    clr = 1'b1;
    tick();
    chk("clr_to0", 32'(count_a), 32'd0);
    clr = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("clr_reach15", 32'(count_a), 32'd15);
    clr = 1'b1;
    #1;
    chk("clr_rco_mask", 32'(rco_a), 32'd0);
    clr = 1'b0;
    #1;
    chk("clr_rco_unmask", 32'(rco_a), 32'd1);
`endif

    // Two-stage cascade: stage1 advances once per 16 stage0 edges.
    do_reset();
    en_c = 1'b1;
    for (t_c = 1; t_c <= 40; t_c++) begin
      tick();
      chk("casc_c0", 32'(count_c0), 32'(t_c % 16));
      chk("casc_c1", 32'(count_c1), 32'((t_c / 16) % 16));
    end
    chk("casc_final_c0", 32'(count_c0), 32'd8);
    chk("casc_final_c1", 32'(count_c1), 32'd2);
    en_c = 1'b0;

    // Randomized enable/clear against a modulo-16 count of enabled edges.
    do_reset();
    m_a = 0;
    for (int i = 0; i < 300; i++) begin
      en_a = ($urandom_range(0, 3) != 0);
`ifdef COUNTER_CLR_EN
      clr = ($urandom_range(0, 15) == 0);
`endif
      #1;
      chk("rand_rco", 32'(rco_a), 32'(en_a && !clr && (m_a == 15)));
      tick();
      if (clr) m_a = 0;
      else if (en_a) m_a = (m_a + 1) % 16;
      chk("rand_count", 32'(count_a), 32'(m_a));
    end
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_counter_rco
